alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters. The ALU has 32-bit operands, a 10-bit {func7,func3} selector, a 32-bit result and a zero flag. The block arbitrates round-robin between requester 0 and requester 1. It registers the operands that drive the ALU, captures the result, and returns it with a valid/ready response handshake. It sits between the decode/issue logic and the shared alu instance.

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result is captured and returned with a valid/ready handshake.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [SEL_W-1:0] r0_func,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_result,
    output logic             r0_zero,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [SEL_W-1:0] r1_func,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_result,
    output logic             r1_zero,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_in0;
    logic [WIDTH-1:0] r_in1;
    logic [SEL_W-1:0] r_sel;

    logic [1:0]       w_valid;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_ready;
    logic [1:0]       w_rsp_valid;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_a    [2];
    logic [WIDTH-1:0] w_b    [2];
    logic [SEL_W-1:0] w_func [2];
    logic [WIDTH-1:0] r_result [2];
    logic             r_zero   [2];

    assign w_valid     = {r1_valid, r0_valid};
    assign w_rsp_ready = {r1_rsp_ready, r0_rsp_ready};
    assign w_a[0]      = r0_a;
    assign w_a[1]      = r1_a;
    assign w_b[0]      = r0_b;
    assign w_b[1]      = r1_b;
    assign w_func[0]   = r0_func;
    assign w_func[1]   = r1_func;

    // A lone valid requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_grant = r_ptr;
        if (!r0_valid) begin
            w_grant = 1'b1;
        end else if (!r1_valid) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (!rst && (|w_valid)) begin
                    w_ready[w_grant] = 1'b1;
                    w_state_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_ready[r_owner]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = |w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_in0   <= '0;
            r_in1   <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_in0   <= w_a[w_grant];
                r_in1   <= w_b[w_grant];
                r_sel   <= w_func[w_grant];
                r_owner <= w_grant;
                r_ptr   <= ~w_grant;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // Result registers keep their last capture; rsp_valid alone qualifies them.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_result[gi] <= '0;
                    r_zero[gi]   <= 1'b0;
                end else if (r_state == S_EXEC && r_owner == 1'(gi)) begin
                    r_result[gi] <= alu_out;
                    r_zero[gi]   <= alu_zero;
                end
            end
            assign w_rsp_valid[gi] = (r_state == S_RESP) && (r_owner == 1'(gi));
        end
    endgenerate

    assign r0_ready     = w_ready[0];
    assign r1_ready     = w_ready[1];
    assign r0_rsp_valid = w_rsp_valid[0];
    assign r1_rsp_valid = w_rsp_valid[1];
    assign r0_result    = r_result[0];
    assign r1_result    = r_result[1];
    assign r0_zero      = r_zero[0];
    assign r1_zero      = r_zero[1];
    assign alu_in0      = r_in0;
    assign alu_in1      = r_in1;
    assign alu_sel      = r_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stands in for the shared instance, and a
// transaction-level model (grant pointer + expected results) predicts every response.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int SEL_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_zero;
    logic             r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_zero;
    logic [WIDTH-1:0] r0_a, r0_b, r0_result, r1_a, r1_b, r1_result;
    logic [SEL_W-1:0] r0_func, r1_func;
    logic [WIDTH-1:0] alu_in0, alu_in1, alu_out;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_zero;

    int   checks = 0;
    int   errors = 0;
    logic exp_ptr = 1'b0;

    alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_func(r0_func),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_zero(r0_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_func(r1_func),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_zero(r1_zero),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [SEL_W-1:0] f);
        case (f)
            10'h000: ref_alu = a + b;
            10'h001: ref_alu = a << b[4:0];
            10'h100: ref_alu = a - b;
            10'h004: ref_alu = a ^ b;
            10'h006: ref_alu = a | b;
            10'h007: ref_alu = a & b;
            default: ref_alu = a + b;
        endcase
    endfunction

    function automatic logic [SEL_W-1:0] pick_func(input int unsigned i);
        case (i)
            0:       pick_func = 10'h000;
            1:       pick_func = 10'h001;
            2:       pick_func = 10'h100;
            3:       pick_func = 10'h004;
            4:       pick_func = 10'h006;
            default: pick_func = 10'h007;
        endcase
    endfunction

    always_comb begin
        alu_out  = ref_alu(alu_in0, alu_in1, alu_sel);
        alu_zero = (alu_out == '0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        r0_a    = $urandom;
        r0_func = pick_func($urandom_range(0, 5));
        r0_b    = ($urandom_range(0, 3) == 0) ? r0_a : $urandom;
        r1_a    = $urandom;
        r1_func = pick_func($urandom_range(0, 5));
        r1_b    = ($urandom_range(0, 3) == 0) ? r1_a : $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_ptr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        rand_ops();
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {r0_ready, r1_ready});
        end
        step();
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
        exp_ptr = 1'b0;
        #1;
        checks++;
        if ({alu_in0, alu_in1, alu_sel} !== '0) begin
            errors++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_in0, alu_in1, alu_sel);
        end
        checks++;
        if ({r0_result, r1_result, r0_zero, r1_zero, r0_rsp_valid, r1_rsp_valid} !== '0) begin
            errors++; $display("FAIL reset_rsp: got %h %h %b%b %b%b expected 0", r0_result, r1_result,
                               r0_zero, r1_zero, r0_rsp_valid, r1_rsp_valid);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_add();
        step();
        r0_a = 5; r0_b = 5; r0_func = 10'b0000000000; r0_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++; $display("FAIL add_ready: got %b expected 10", {r0_ready, r1_ready});
        end
        exp_ptr = 1'b1;
        step();
        r0_valid = 1'b0;
        #1;
        checks++;
        if (r0_rsp_valid !== 1'b0 || alu_in0 !== 32'd5 || alu_in1 !== 32'd5) begin
            errors++; $display("FAIL add_exec: got rsp=%b in0=%0d in1=%0d expected 0 5 5", r0_rsp_valid, alu_in0, alu_in1);
        end
        step();
        #1;
        checks++;
        if (r0_rsp_valid !== 1'b1 || r0_result !== 32'd10 || r0_zero !== 1'b0 || r1_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_rsp: got v=%b res=%0d z=%b v1=%b expected 1 10 0 0",
                               r0_rsp_valid, r0_result, r0_zero, r1_rsp_valid);
        end
        step();
        #1;
        checks++;
        if (r0_rsp_valid !== 1'b0 || r0_result !== 32'd10) begin
            errors++; $display("FAIL add_hold: got v=%b res=%0d expected 0 10", r0_rsp_valid, r0_result);
        end
        $display("add: r0 5+5 -> %0d", r0_result);
    endtask

    task automatic test_contention();
        do_reset();
        r0_a = 5; r0_b = 1; r0_func = 10'b0000000001;
        r1_a = 7; r1_b = 7; r1_func = 10'b0100000000;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_grant0: got %b expected 10", {r0_ready, r1_ready});
        end
        step();
        r0_valid = 1'b0;
        #1;
        checks++;
        if (r1_ready !== 1'b0) begin
            errors++; $display("FAIL cont_exec_ready: got %b expected 0", r1_ready);
        end
        step();
        #1;
        checks++;
        if (r0_rsp_valid !== 1'b1 || r0_result !== 32'd10 || r0_zero !== 1'b0 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL cont_rsp0: got v=%b res=%0d z=%b r1rdy=%b expected 1 10 0 0",
                               r0_rsp_valid, r0_result, r0_zero, r1_ready);
        end
        step();
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++; $display("FAIL cont_grant1: got %b expected 1", r1_ready);
        end
        step();
        r1_valid = 1'b0;
        step();
        #1;
        checks++;
        if (r1_rsp_valid !== 1'b1 || r1_result !== 32'd0 || r1_zero !== 1'b1 || r0_result !== 32'd10) begin
            errors++; $display("FAIL cont_rsp1: got v=%b res=%0d z=%b r0res=%0d expected 1 0 1 10",
                               r1_rsp_valid, r1_result, r1_zero, r0_result);
        end
        step();
        $display("contention: r0 sll -> 10, r1 sub -> %0d zero=%b", r1_result, r1_zero);
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_res;
        int               who;
        int               exp_who;
        do_reset();
        for (int op = 0; op < 8; op++) begin
            rand_ops();
            r0_valid = 1'b1; r1_valid = 1'b1;
            #1;
            exp_who = int'(exp_ptr);
            who = (r0_ready && !r1_ready) ? 0 : ((r1_ready && !r0_ready) ? 1 : -1);
            checks++;
            if (who !== exp_who) begin
                errors++; $display("FAIL rr_grant op%0d: got %0d expected %0d", op, who, exp_who);
            end
            exp_res = (exp_who == 0) ? ref_alu(r0_a, r0_b, r0_func) : ref_alu(r1_a, r1_b, r1_func);
            exp_ptr = ~exp_ptr;
            step();
            rand_ops();
            #1;
            checks++;
            if ({r0_ready, r1_ready} !== 2'b00) begin
                errors++; $display("FAIL rr_exec_ready op%0d: got %b expected 00", op, {r0_ready, r1_ready});
            end
            step();
            #1;
            checks++;
            if (exp_who == 0) begin
                if (r0_rsp_valid !== 1'b1 || r1_rsp_valid !== 1'b0 || r0_result !== exp_res ||
                    r0_zero !== (exp_res == '0)) begin
                    errors++; $display("FAIL rr_rsp op%0d: got v=%b%b res=%h z=%b expected 10 %h %b", op,
                                       r0_rsp_valid, r1_rsp_valid, r0_result, r0_zero, exp_res, exp_res == '0);
                end
            end else begin
                if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0 || r1_result !== exp_res ||
                    r1_zero !== (exp_res == '0)) begin
                    errors++; $display("FAIL rr_rsp op%0d: got v=%b%b res=%h z=%b expected 01 %h %b", op,
                                       r0_rsp_valid, r1_rsp_valid, r1_result, r1_zero, exp_res, exp_res == '0);
                end
            end
            $display("rr op%0d: grant=%0d result=%h", op, exp_who, exp_res);
            step();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_res;
        logic [WIDTH-1:0] exp_a;
        do_reset();
        rand_ops();
        r1_valid = 1'b1; r0_valid = 1'b0; r1_rsp_ready = 1'b0;
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept: got %b expected 1", r1_ready);
        end
        exp_res = ref_alu(r1_a, r1_b, r1_func);
        exp_a   = r1_a;
        exp_ptr = 1'b0;
        step();
        r1_valid = 1'b0;
        r0_a = $urandom; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
        #1;
        checks++;
        if (r0_ready !== 1'b0) begin
            errors++; $display("FAIL bp_exec_ready: got %b expected 0", r0_ready);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (r1_rsp_valid !== 1'b1 || r1_result !== exp_res || r1_zero !== (exp_res == '0) ||
                r0_ready !== 1'b0 || r0_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL bp_hold c%0d: got v=%b res=%h z=%b r0rdy=%b r0v=%b expected 1 %h %b 0 0", i,
                                   r1_rsp_valid, r1_result, r1_zero, r0_ready, r0_rsp_valid, exp_res, exp_res == '0);
            end
            step();
        end
        r1_rsp_ready = 1'b1;
        #1;
        checks++;
        if (r1_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: got %b expected 1", r1_rsp_valid);
        end
        step();
        #1;
        checks++;
        if (r1_rsp_valid !== 1'b0 || r0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: got v=%b r0rdy=%b expected 0 1", r1_rsp_valid, r0_ready);
        end
        r0_valid = 1'b0;
        step();
        #1;
        checks++;
        if (alu_in0 !== exp_a || r0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_withdraw: got in0=%h v=%b expected %h 0", alu_in0, r0_rsp_valid, exp_a);
        end
        $display("backpressure: r1 result %h held 5 cycles", exp_res);
    endtask

    task automatic test_reset_midop();
        step();
        r0_a = 3; r0_b = 4; r0_func = 10'h000; r0_valid = 1'b1; r1_valid = 1'b0;
        #1;
        checks++;
        if (r0_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_accept: got %b expected 1", r0_ready);
        end
        step();
        r0_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; exp_ptr = 1'b0;
        #1;
        checks++;
        if ({alu_in0, alu_in1, alu_sel, r0_result, r1_result, r0_zero, r1_zero, r0_rsp_valid, r1_rsp_valid,
             r0_ready, r1_ready} !== '0) begin
            errors++; $display("FAIL rst_mid_zero: got in0=%h res0=%h v=%b%b expected 0", alu_in0, r0_result,
                               r0_rsp_valid, r1_rsp_valid);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_norsp c%0d: got %b expected 00", i, {r0_rsp_valid, r1_rsp_valid});
            end
            step();
        end
        r1_a = 1; r1_b = 1; r1_func = 10'h000; r1_valid = 1'b1;
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_next_accept: got %b expected 1", r1_ready);
        end
        exp_ptr = 1'b0;
        step();
        r1_valid = 1'b0;
        #1;
        checks++;
        if (r1_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_early: got %b expected 0", r1_rsp_valid);
        end
        step();
        #1;
        checks++;
        if (r1_rsp_valid !== 1'b1 || r1_result !== 32'd2) begin
            errors++; $display("FAIL rst_mid_next_rsp: got v=%b res=%0d expected 1 2", r1_rsp_valid, r1_result);
        end
        step();
        $display("reset_midop: discarded 3+4, then r1 1+1 -> %0d", r1_result);
    endtask

    task automatic test_withdraw();
        logic [WIDTH-1:0] exp_a, exp_b, exp_res;
        logic [SEL_W-1:0] exp_f;
        rand_ops();
        r0_valid = 1'b1; r1_valid = 1'b0;
        #1;
        checks++;
        if (r0_ready !== 1'b1) begin
            errors++; $display("FAIL wd_accept: got %b expected 1", r0_ready);
        end
        exp_a = r0_a; exp_b = r0_b; exp_f = r0_func;
        exp_res = ref_alu(r0_a, r0_b, r0_func);
        exp_ptr = 1'b1;
        step();
        r0_valid = 1'b0;
        r1_a = ~exp_a; r1_b = ~exp_b; r1_func = 10'h007; r1_valid = 1'b1;
        #1;
        checks++;
        if (r1_ready !== 1'b0) begin
            errors++; $display("FAIL wd_busy_ready: got %b expected 0", r1_ready);
        end
        step();
        r1_valid = 1'b0;
        #1;
        checks++;
        if (alu_in0 !== exp_a || alu_in1 !== exp_b || alu_sel !== exp_f || r0_result !== exp_res) begin
            errors++; $display("FAIL wd_resp: got %h %h %h res=%h expected %h %h %h %h", alu_in0, alu_in1, alu_sel,
                               r0_result, exp_a, exp_b, exp_f, exp_res);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (r1_rsp_valid !== 1'b0 || alu_in0 !== exp_a || alu_in1 !== exp_b || alu_sel !== exp_f) begin
                errors++; $display("FAIL wd_idle c%0d: got v=%b %h %h %h expected 0 %h %h %h", i, r1_rsp_valid,
                                   alu_in0, alu_in1, alu_sel, exp_a, exp_b, exp_f);
            end
            step();
        end
        $display("withdraw: r1 pulse while busy ignored, r0 result %h", exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = '0; r0_b = '0; r0_func = '0;
        r1_a = '0; r1_b = '0; r1_func = '0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        step();
        test_reset();
        test_add();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
